// File: rtl/digit_glyph_writer_if.sv
// digit_glyph_writer_if: request, font ROM and framebuffer write signals of the glyph writer
//   start_in/value_in/x_in/y_in : render request (BCD value, top-left position)
//   font_addr_out/font_data_in  : font ROM read port (2-cycle latency)
//   fb_addr_out/fb_data_out/fb_we_out : framebuffer write port
//   busy_out/done_out           : status
interface digit_glyph_writer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int FONT_AW    = 13,
    parameter int FB_AW      = 16
);
    logic                    start_in;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [10:0]             x_in;
    logic [9:0]              y_in;
    logic [FONT_AW-1:0]      font_addr_out;
    logic                    font_data_in;
    logic [FB_AW-1:0]        fb_addr_out;
    logic                    fb_data_out;
    logic                    fb_we_out;
    logic                    busy_out;
    logic                    done_out;
    modport slave (
        input  start_in, value_in, x_in, y_in, font_data_in,
        output font_addr_out, fb_addr_out, fb_data_out, fb_we_out, busy_out, done_out
    );
    modport master (
        output start_in, value_in, x_in, y_in, font_data_in,
        input  font_addr_out, fb_addr_out, fb_data_out, fb_we_out, busy_out, done_out
    );
endinterface

// File: rtl/digit_glyph_writer.sv
// digit_glyph_writer: copies NUM_DIGITS BCD font glyphs from the font ROM into a 1-bit framebuffer
//   pixel_clk_in : clock, rising edge
//   rst_n_in     : asynchronous active-low reset
//   bus          : request / font ROM / framebuffer signals (slave modport)
module digit_glyph_writer #(
    parameter int GLYPH_W    = 24,
    parameter int GLYPH_H    = 24,
    parameter int NUM_GLYPHS = 10,
    parameter int NUM_DIGITS = 4,
    parameter int FB_W       = 320,
    parameter int FB_H       = 180
) (
    input logic                 pixel_clk_in,
    input logic                 rst_n_in,
    digit_glyph_writer_if.slave bus
);
    localparam int GSZ     = GLYPH_W * GLYPH_H;
    localparam int FONT_AW = $clog2(GSZ * NUM_GLYPHS);
    localparam int FB_AW   = $clog2(FB_W * FB_H);
    localparam int CW      = GLYPH_W > 1 ? $clog2(GLYPH_W) : 1;
    localparam int RW      = GLYPH_H > 1 ? $clog2(GLYPH_H) : 1;
    localparam int DW      = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t                  r_state, w_next;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [10:0]             r_x;
    logic [9:0]              r_y;
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [DW-1:0]           r_dig;
    logic [1:0]              r_drain;
    logic [FONT_AW-1:0]      r_font_addr;
    // sideband stages aligned with the ROM latency; valid already folds in clipping
    logic                    r_p_vld   [3];
    logic                    r_p_blank [3];
    logic [FB_AW-1:0]        r_p_addr  [3];
    logic                    r_fb_we, r_fb_data, r_done;
    logic [FB_AW-1:0]        r_fb_addr;
    logic [3:0]              w_glyph;
    logic                    w_blank, w_col_end, w_row_end, w_last, w_in_range;
    logic [31:0]             w_px, w_py, w_font_addr, w_fb_addr;
    assign w_glyph     = r_value[4*(NUM_DIGITS-1-int'(r_dig)) +: 4];
    assign w_blank     = 32'(w_glyph) >= NUM_GLYPHS;
    assign w_col_end   = r_col == CW'(GLYPH_W-1);
    assign w_row_end   = r_row == RW'(GLYPH_H-1);
    assign w_last      = w_col_end && w_row_end && r_dig == DW'(NUM_DIGITS-1);
    // wide arithmetic so positions past the framebuffer edge are clipped, never wrapped
    assign w_px        = 32'(r_x) + 32'(r_dig) * GLYPH_W + 32'(r_col);
    assign w_py        = 32'(r_y) + 32'(r_row);
    assign w_in_range  = w_px < FB_W && w_py < FB_H;
    assign w_fb_addr   = w_py * FB_W + w_px;
    assign w_font_addr = w_blank ? 32'd0 : 32'(w_glyph) * GSZ + 32'(r_row) * GLYPH_W + 32'(r_col);
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE  && bus.start_in)  ? ISSUE :
                 (r_state == ISSUE && w_last)        ? DRAIN :
                 (r_state == DRAIN && r_drain == 2'd2) ? IDLE : r_state;
    end
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_value     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_dig       <= '0;
            r_drain     <= '0;
            r_font_addr <= '0;
            r_p_vld     <= '{default: 1'b0};
            r_p_blank   <= '{default: 1'b0};
            r_p_addr    <= '{default: '0};
            r_fb_we     <= 1'b0;
            r_fb_data   <= 1'b0;
            r_fb_addr   <= '0;
            r_done      <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.start_in) begin
                r_value <= bus.value_in;
                r_x     <= bus.x_in;
                r_y     <= bus.y_in;
                r_col   <= '0;
                r_row   <= '0;
                r_dig   <= '0;
            end
            if (r_state == ISSUE) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
                if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
                if (w_col_end && w_row_end) r_dig <= r_dig + 1'b1;
            end
            r_drain      <= r_state == DRAIN ? r_drain + 2'd1 : 2'd0;
            r_font_addr  <= r_state == ISSUE ? FONT_AW'(w_font_addr) : '0;
            r_p_vld[0]   <= r_state == ISSUE && w_in_range;
            r_p_blank[0] <= w_blank;
            r_p_addr[0]  <= FB_AW'(w_fb_addr);
            for (int i = 1; i < 3; i++) begin
                r_p_vld[i]   <= r_p_vld[i-1];
                r_p_blank[i] <= r_p_blank[i-1];
                r_p_addr[i]  <= r_p_addr[i-1];
            end
            r_fb_we      <= r_p_vld[2];
            r_fb_addr    <= r_p_addr[2];
            r_fb_data    <= bus.font_data_in & ~r_p_blank[2];
            r_done       <= r_state == DRAIN && r_drain == 2'd2;
        end
    end
    assign bus.font_addr_out = r_font_addr;
    assign bus.fb_addr_out   = r_fb_addr;
    assign bus.fb_data_out   = r_fb_data;
    assign bus.fb_we_out     = r_fb_we;
    assign bus.done_out      = r_done;
    assign bus.busy_out      = r_state != IDLE;
endmodule

// File: tb/tb_digit_glyph_writer.sv
// tb_digit_glyph_writer: randomized scoreboard bench for digit_glyph_writer
module tb_digit_glyph_writer;
    localparam int GW = 24, GH = 24, ND = 4, FBW = 320, FBH = 180;
    localparam int ROM_SZ = GW * GH * 10;
    localparam int RENDER = ND * GW * GH + 3;
    typedef struct packed {logic [15:0] a; logic d;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rom [ROM_SZ];
    logic rd1 = 1'b0;
    bit   ignore_mon = 1'b0;
    int   n_checks = 0, n_fail = 0, n_writes = 0;
    exp_t q [$];
    exp_t mon_e;
    digit_glyph_writer_if bus ();
    digit_glyph_writer dut (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        rd1 <= (int'(bus.font_addr_out) < ROM_SZ) ? rom[bus.font_addr_out] : 1'b0;
        bus.font_data_in <= rd1;
    end
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && !ignore_mon && bus.fb_we_out) begin
            n_writes++;
            check("wr_addr_in_fb", int'(bus.fb_addr_out < 16'(FBW*FBH)), 1);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d with empty scoreboard", bus.fb_addr_out, bus.fb_data_out);
            end else begin
                mon_e = q.pop_front();
                check("wr_addr", int'(bus.fb_addr_out), int'(mon_e.a));
                check("wr_data", int'(bus.fb_data_out), int'(mon_e.d));
            end
        end
    end
    task automatic fill_rom(input bit parity);
        for (int i = 0; i < ROM_SZ; i++) rom[i] = parity ? logic'(^i) : logic'($urandom_range(0, 1));
    endtask
    task automatic run(input logic [15:0] v, input int x, input int y, input bit hold, input bit chain);
        int first_k, k, done_j, first_we, w0, n_exp, g, px, py;
        first_k = -1;
        k = 0;
        n_exp = 0;
        if (!chain) begin
            @(negedge clk);
            bus.value_in = v;
            bus.x_in = 11'(x);
            bus.y_in = 10'(y);
            bus.start_in = 1'b1;
        end
        w0 = n_writes;
        for (int d = 0; d < ND; d++)
            for (int r = 0; r < GH; r++)
                for (int c = 0; c < GW; c++) begin
                    g  = int'(v[4*(ND-1-d) +: 4]);
                    px = x + d * GW + c;
                    py = y + r;
                    if (px < FBW && py < FBH) begin
                        q.push_back('{a: 16'(py * FBW + px), d: g > 9 ? 1'b0 : rom[g*GW*GH + r*GW + c]});
                        if (first_k < 0) first_k = k;
                        n_exp++;
                    end
                    k++;
                end
        @(posedge clk);
        done_j = -1;
        first_we = -1;
        for (int j = 0; j < RENDER + 50; j++) begin
            @(negedge clk);
            if (!hold) bus.start_in = 1'b0;
            if (j == 0) check("busy_after_start", int'(bus.busy_out), 1);
            if (bus.fb_we_out && first_we < 0) first_we = j;
            if (bus.done_out) begin
                done_j = j;
                break;
            end
        end
        check("done_cycle", done_j, RENDER);
        check("busy_at_done", int'(bus.busy_out), 0);
        check("first_we_cycle", first_we, first_k < 0 ? -1 : first_k + 4);
        if (!hold) begin
            @(negedge clk);
            check("sb_drained", q.size(), 0);
            if (!chain) check("write_count", n_writes - w0, n_exp);
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start_in = 1'b0;
        bus.value_in = '0;
        bus.x_in = '0;
        bus.y_in = '0;
        fill_rom(1'b0);
        #12;
        check("rst_busy", int'(bus.busy_out), 0);
        check("rst_done", int'(bus.done_out), 0);
        check("rst_we", int'(bus.fb_we_out), 0);
        check("rst_font_addr", int'(bus.font_addr_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ignore_mon = 1'b1;
        @(negedge clk);
        bus.value_in = 16'h1234;
        bus.x_in = 11'd10;
        bus.y_in = 10'd10;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy_out), 0);
        check("midrst_we", int'(bus.fb_we_out), 0);
        check("midrst_font_addr", int'(bus.font_addr_out), 0);
        check("midrst_fb_addr", int'(bus.fb_addr_out), 0);
        check("midrst_fb_data", int'(bus.fb_data_out), 0);
        check("midrst_done", int'(bus.done_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ignore_mon = 1'b0;
        run(16'h0007, 0, 0, 1'b0, 1'b0);
        run(16'h12F9, 20, 30, 1'b0, 1'b0);
        run(16'h0000, 300, 170, 1'b0, 1'b0);
        run(16'h4321, 50, 60, 1'b1, 1'b0);
        run(16'h4321, 50, 60, 1'b0, 1'b1);
        fill_rom(1'b1);
        run(16'h5678, 5, 100, 1'b0, 1'b0);
        fill_rom(1'b0);
        for (int i = 0; i < 5; i++)
            run(16'($urandom_range(0, 65535)), int'($urandom_range(0, 340)), int'($urandom_range(0, 200)), 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
